conf_int_div__seq__acc_apx: RTL and testbench
=============================================

# conf_int_div__seq__acc_apx

Sequential restoring integer divider with selectable accurate/approximate mode. It is the inverse datapath of the configurable accurate/approximate multiplier. It takes a 2W-bit dividend (the width of a multiplier product) and a W-bit divisor, and produces a W-bit quotient and remainder over several cycles under a start/busy/done handshake. Approximate mode skips the low APX_DROP_BITS quotient iterations to trade accuracy for latency and energy in the same accelerator datapath as the multiplier.

## Interface
- DATA_PATH_BITWIDTH, 32, W: divisor, quotient and remainder width; dividend is 2W.
- APX_DROP_BITS, 8, D: low quotient bits not computed in approximate mode; 1 ≤ D < W.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only in IDLE.
- acc__sel  input  1  1 = accurate, 0 = approximate; sampled with accepted start.
- a  input  2W  dividend; sampled with accepted start.
- b  input  W  divisor; sampled with accepted start.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle completion pulse.
- q  output  W  quotient.
- r  output  W  remainder.
- err  output  1  divide-by-zero or quotient overflow for the last completed operation.

## Operation
- Reset (rst low, asynchronous): state IDLE; busy, done, q, r and err are 0; internal registers are cleared. This applies mid-operation. The in-flight result is discarded and nothing is reported.
- States:
  - IDLE → RUN on start when there is no error condition.
  - IDLE → DONE on start when an error condition is detected.
  - RUN → DONE when the iteration count reaches N.
  - DONE → IDLE unconditionally.
- Error condition, checked at start: a[2W-1:W] ≥ b. This covers b = 0.
- Iteration count N: W if acc__sel = 1, otherwise W−D.
- Datapath (restoring):
  - The partial remainder register is W+1 bits, initialised to {1'b0, a[2W-1:W]}.
  - Dividend-low shift register is initialised to a[W-1:0].
  - Each RUN cycle:
    - rem' = {rem[W-1:0], msb of low shift};
    - if rem' ≥ b, rem' −= b and shift 1 into the quotient, else shift 0;
    - shift the low register left by 1.
- Accurate result:
  - q = floor(a/b);
  - r = a mod b.
- Approximate result:
  - q = computed W−D bits followed by D zeros. The upper W−D bits are exact: q = floor(a/b) with the low D bits cleared.
  - r = 0.
- Error result: q = all ones, r = 0, err = 1.
- q, r and err update only on the cycle done is high. They hold their values until the next completion or reset.
- start outside IDLE, including the DONE cycle, is ignored. No queuing.
- acc__sel, a and b changes after acceptance have no effect on the in-flight operation.

## Timing
- The accepting edge is at cycle t, with start high and state IDLE.
- busy is high from t+1 through the done cycle, inclusive.
- Normal operation: RUN occupies cycles t+1 … t+N; done = 1 at t+N+1.
  - Accurate, W=32: done at t+33.
  - Approximate, D=8: done at t+25.
- Error: done = 1 at t+1, with no RUN cycles.
- The earliest next accepted start is the cycle after done; busy is 0 in that cycle.
- Throughput, accurate: one operation per N+2 cycles.
- There are no combinational paths from inputs to outputs.

## Test plan
- Accurate, a=100, b=7, acc__sel=1 → done at t+33, q=14, r=2, err=0; busy high t+1..t+33.
- Approximate, a=0x0000_0000_FFFF_FFFF, b=16, acc__sel=0 → done at t+25, q=0x0FFF_FF00, r=0, err=0. The accurate run of the same operands gives q=0x0FFF_FFFF, r=15.
- Maximum operands, a=0xFFFF_FFFE_0000_0001, b=0xFFFF_FFFF, accurate → q=0xFFFF_FFFF, r=0, err=0. This exercises the W+1-bit remainder.
- Errors:
  - b=0, a=5 → done at t+1, err=1, q=0xFFFF_FFFF, r=0.
  - a=0x0000_0001_0000_0000, b=1 → done at t+1, err=1.
- Start while busy, re-issued at t+5 with different operands → ignored; the first result is reported unchanged at t+33.
- Reset mid-run, rst low at t+10 → busy, done, q, r and err are 0 immediately, with no done pulse. After release, a new start a=100, b=7 completes correctly.

Source files
------------

// File: rtl/conf_int_div__seq__acc_apx.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor. In approximate
// mode the low APX_DROP_BITS quotient iterations are skipped and those bits read as zero.
module conf_int_div__seq__acc_apx #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int APX_DROP_BITS      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            acc__sel,
    input  logic [2*DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_PATH_BITWIDTH-1:0]   q,
    output logic [DATA_PATH_BITWIDTH-1:0]   r,
    output logic                            err
);
    localparam int W  = DATA_PATH_BITWIDTH;
    localparam int D  = APX_DROP_BITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_lo;
    logic [W-2:0]    r_quo;
    logic [W-1:0]    r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_acc;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_r;
    logic            r_err;

    logic            w_div_err;
    logic            w_last;
    logic [W:0]      w_rem_shift;
    logic [W-1:0]    w_rem_sub;
    logic [W-1:0]    w_rem_next;
    logic            w_q_bit;
    logic [W-1:0]    w_quo_next;

    assign w_div_err = (a[2*W-1:W] >= b);
    assign w_last    = (r_cnt == CW'(1));
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign q         = r_q;
    assign r         = r_r;
    assign err       = r_err;

    // One restoring step; the partial remainder is always below the divisor, so
    // the W-bit difference never loses information.
    always_comb begin
        w_rem_shift = {r_rem, r_lo[W-1]};
        w_rem_sub   = w_rem_shift[W-1:0] - r_div;
        if (w_rem_shift >= {1'b0, r_div}) begin
            w_q_bit    = 1'b1;
            w_rem_next = w_rem_sub;
        end else begin
            w_q_bit    = 1'b0;
            w_rem_next = w_rem_shift[W-1:0];
        end
        w_quo_next = {r_quo, w_q_bit};
    end

    // Next-state selection for the handshake FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_div_err) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, iteration and result registers; results load only on the
    // edge that enters DONE so they are valid exactly when done rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= {W{1'b0}};
            r_lo  <= {W{1'b0}};
            r_quo <= {(W-1){1'b0}};
            r_div <= {W{1'b0}};
            r_cnt <= {CW{1'b0}};
            r_acc <= 1'b0;
            r_q   <= {W{1'b0}};
            r_r   <= {W{1'b0}};
            r_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc <= acc__sel;
                        r_div <= b;
                        r_rem <= a[2*W-1:W];
                        r_lo  <= a[W-1:0];
                        r_quo <= {(W-1){1'b0}};
                        r_cnt <= acc__sel ? CW'(W) : CW'(W - D);
                        if (w_div_err) begin
                            r_q   <= {W{1'b1}};
                            r_r   <= {W{1'b0}};
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_lo  <= {r_lo[W-2:0], 1'b0};
                    r_quo <= w_quo_next[W-2:0];
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_q   <= r_acc ? w_quo_next : (w_quo_next << D);
                        r_r   <= r_acc ? w_rem_next : {W{1'b0}};
                        r_err <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conf_int_div__seq__acc_apx.sv
// Self-checking bench: directed vector table, corner sequences and random
// operands compared against a plain-arithmetic division model.
module tb_conf_int_div__seq__acc_apx;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc__sel;
    logic [63:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        err;

    int total = 0;
    int bad   = 0;

    conf_int_div__seq__acc_apx #(
        .DATA_PATH_BITWIDTH(32),
        .APX_DROP_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .acc__sel(acc__sel),
        .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic        acc;
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ordinary 64-bit division, then the approximate truncation.
    task automatic model(input logic [63:0] av, input logic [31:0] bv, input logic acc,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic ee, output int lat);
        logic [63:0] qq;
        logic [63:0] rr;
        if (av[63:32] >= bv) begin
            eq = 32'hFFFF_FFFF; er = 32'd0; ee = 1'b1; lat = 1;
        end else begin
            qq = av / {32'd0, bv};
            rr = av % {32'd0, bv};
            ee = 1'b0;
            if (acc) begin
                eq = qq[31:0]; er = rr[31:0]; lat = 33;
            end else begin
                eq = qq[31:0] & 32'hFFFF_FF00; er = 32'd0; lat = 25;
            end
        end
    endtask

    task automatic run_op(input logic [63:0] av, input logic [31:0] bv, input logic acc,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee,
                          input int elat, input string tag);
        int   k;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; acc__sel = acc;
        @(posedge clk);
        busy_ok = 1'b1;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = {$urandom, $urandom}; b = $urandom; acc__sel = ~acc;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                k = i;
                break;
            end
        end
        chk({tag, " latency"}, 64'(k), 64'(elat));
        chk({tag, " busy"}, 64'(busy_ok), 64'd1);
        chk({tag, " q"}, 64'(q), 64'(eq));
        chk({tag, " r"}, 64'(r), 64'(er));
        chk({tag, " err"}, 64'(err), 64'(ee));
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(done), 64'd0);
        chk({tag, " idle busy"}, 64'(busy), 64'd0);
        chk({tag, " q hold"}, 64'(q), 64'(eq));
    endtask

    initial begin
        logic [31:0] eq, er;
        logic        ee;
        int          lat, k, extra;
        logic [63:0] av;
        logic [31:0] bv;
        logic        acc;

        vecs[0] = '{64'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 33};
        vecs[1] = '{64'h0000_0000_FFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FF00, 32'd0, 1'b0, 25};
        vecs[2] = '{64'h0000_0000_FFFF_FFFF, 32'd16, 1'b1, 32'h0FFF_FFFF, 32'd15, 1'b0, 33};
        vecs[3] = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
        vecs[4] = '{64'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1};
        vecs[5] = '{64'h0000_0001_0000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1};
        vecs[6] = '{64'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 25};
        vecs[7] = '{64'h0000_0000_0001_2345, 32'd3, 1'b0, 32'h0000_6100, 32'd0, 1'b0, 25};

        rst = 1'b0; start = 1'b0; acc__sel = 1'b0; a = 64'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset q", 64'(q), 64'd0);
        chk("reset r", 64'(r), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].q, vecs[i].r,
                   vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Start re-issued while busy must be ignored.
        @(negedge clk);
        start = 1'b1; a = 64'd100; b = 32'd7; acc__sel = 1'b1;
        @(posedge clk);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = (i == 4);
            if (i == 4) begin
                a = 64'd1000; b = 32'd3; acc__sel = 1'b0;
            end
            if (done) begin
                k = i;
                break;
            end
        end
        chk("busy-start latency", 64'(k), 64'd33);
        chk("busy-start q", 64'(q), 64'd14);
        chk("busy-start r", 64'(r), 64'd2);
        start = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("busy-start no second op", 64'(extra), 64'd0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; a = 64'h0000_0000_FFFF_FFFF; b = 32'd16; acc__sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset q", 64'(q), 64'd0);
        chk("midreset r", 64'(r), 64'd0);
        chk("midreset err", 64'(err), 64'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("midreset no done", 64'(extra), 64'd0);
        run_op(64'd100, 64'd7, 1'b1, 32'd14, 32'd2, 1'b0, 33, "after reset");

        // Random operands, mostly valid, with some forced overflow cases.
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: bv = $urandom_range(1, 255);
                1: bv = $urandom | 32'h8000_0000;
                default: bv = $urandom;
            endcase
            if (bv == 32'd0) bv = 32'd1;
            av[31:0] = $urandom;
            if (i % 7 == 3) av[63:32] = bv;
            else av[63:32] = $urandom % bv;
            acc = 1'($urandom);
            model(av, bv, acc, eq, er, ee, lat);
            run_op(av, bv, acc, eq, er, ee, lat, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
